// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding, default sizes and slot addressing for the TDM demultiplexer.
package tdm_pkg;
    typedef enum logic {IDLE, RECV} state_e;
    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 8;
    // A frame-start beat always lands in slot 0, whatever the counter holds.
    function automatic int unsigned slot_idx(input logic start, input int unsigned cnt);
        return start ? 0 : cnt;
    endfunction
endpackage

// File: rtl/slot_decoder.sv
// slot_decoder: one-hot shadow-register write enables from the slot index and beat valid.
module slot_decoder #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 2
) (
    input  logic [CNT_W-1:0]  slot,
    input  logic              valid,
    output logic [NUM_CH-1:0] we
);
    for (genvar k = 0; k < NUM_CH; k++) begin : g_we
        assign we[k] = valid && (slot == CNT_W'(k));
    end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: serial slot stream to NUM_CH parallel channel registers, updated atomically per frame.
// Build with TDM_PARITY_CHECK_EN to add din_par and reject frames containing a parity error.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_start,
`ifdef TDM_PARITY_CHECK_EN
    input  logic                     din_par,
`endif
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic                     busy
);
    state_e                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [NUM_CH-1:0][DATA_W-1:0]  shadow_q, shadow_d, ch_q;
    logic [NUM_CH-1:0]              we;
    logic                           done_q, err_q;
    logic                           start, beat, last, frame_bad;

    assign start = din_valid && frame_start;
    assign beat  = din_valid && !frame_start && state_q == RECV;
    assign last  = beat && cnt_q == CNT_W'(NUM_CH - 1);

    slot_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_dec (
        .slot  (CNT_W'(slot_idx(start, 32'(cnt_q)))),
        .valid (start || beat),
        .we    (we)
    );

    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_CH; k++) shadow_d[k] = we[k] ? din : shadow_q[k];
    end

`ifdef TDM_PARITY_CHECK_EN
    logic bad_q, par_bad;
    assign par_bad   = ^{din, din_par};
    // Includes the final beat's own parity so a bad last slot is caught at completion.
    assign frame_bad = bad_q || (beat && par_bad);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bad_q <= 1'b0;
        else     bad_q <= last ? 1'b0 : start ? par_bad : frame_bad;
    end
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            ch_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            done_q   <= last && !frame_bad;
            err_q    <= (start && state_q == RECV) || (last && frame_bad);
            if (start) begin
                state_q <= RECV;
                cnt_q   <= CNT_W'(1);
            end else if (last) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                if (!frame_bad) ch_q <= shadow_d;
            end else if (beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ch_data    = ch_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = state_q == RECV;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux with NUM_CH=4, DATA_W=8.
module tb_tdm_demux;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0, frame_start = 1'b0, din_par = 1'b0;
    logic [31:0] ch_data;
    logic        frame_done, frame_err, busy;
    int          n_tests = 0, n_fail = 0;

    tdm_demux #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
`ifdef TDM_PARITY_CHECK_EN
        .din_par     (din_par),
`endif
        .ch_data     (ch_data),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted-or-dropped beat; on return the registered response to it is visible.
    task automatic send(input logic [7:0] w, input logic fs, input logic par_flip = 1'b0);
        din         = w;
        din_valid   = 1'b1;
        frame_start = fs;
        din_par     = (^w) ^ par_flip;
        tick();
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [31:0] ch, input logic d, input logic e, input logic b);
        chk({tag, ".ch"}, ch_data, ch);
        chk({tag, ".done"}, 32'(frame_done), 32'(d));
        chk({tag, ".err"}, 32'(frame_err), 32'(e));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        tick();
        tick();
        outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        send(8'h11, 1'b1);
        outs("norm_s0", 32'h0, 1'b0, 1'b0, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        outs("norm_s2", 32'h0, 1'b0, 1'b0, 1'b1);
        send(8'h44, 1'b0);
        outs("norm_done", 32'h44332211, 1'b1, 1'b0, 1'b0);
        tick();
        outs("norm_after", 32'h44332211, 1'b0, 1'b0, 1'b0);

        send(8'h11, 1'b1);
        foreach (din[i]) begin end
        for (int s = 1; s < 4; s++) begin
            for (int g = 0; g < 3; g++) begin
                tick();
                outs($sformatf("gap_%0d_%0d", s, g), 32'h44332211, 1'b0, 1'b0, 1'b1);
            end
            send(8'(8'h11 * (s + 1)), 1'b0);
        end
        outs("gap_done", 32'h44332211, 1'b1, 1'b0, 1'b0);

        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        send(8'h01, 1'b1);
        outs("abort_err", 32'h44332211, 1'b0, 1'b1, 1'b1);
        send(8'h02, 1'b0);
        outs("abort_s1", 32'h44332211, 1'b0, 1'b0, 1'b1);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        outs("abort_done", 32'h04030201, 1'b1, 1'b0, 1'b0);

        send(8'h55, 1'b0);
        outs("stray", 32'h04030201, 1'b0, 1'b0, 1'b0);
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        outs("b2b_a", 32'hA4A3A2A1, 1'b1, 1'b0, 1'b0);
        send(8'hB1, 1'b1);
        outs("b2b_b0", 32'hA4A3A2A1, 1'b0, 1'b0, 1'b1);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b0);
        outs("b2b_b", 32'hB4B3B2B1, 1'b1, 1'b0, 1'b0);

        send(8'hC1, 1'b1);
        send(8'hC2, 1'b0);
        #2 rst = 1'b1;
        #1 outs("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hD1, 1'b1);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b0);
        outs("post_rst", 32'hD4D3D2D1, 1'b1, 1'b0, 1'b0);

`ifdef TDM_PARITY_CHECK_EN
        send(8'hE1, 1'b1);
        send(8'hE2, 1'b0);
        send(8'hE3, 1'b0, 1'b1);
        send(8'hE4, 1'b0);
        outs("par_bad", 32'hD4D3D2D1, 1'b0, 1'b1, 1'b0);
        send(8'hF1, 1'b1);
        send(8'hF2, 1'b0);
        send(8'hF3, 1'b0);
        send(8'hF4, 1'b0);
        outs("par_clean", 32'hF4F3F2F1, 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: receives a serial word stream framed by a start marker and distributes consecutive slots to NUM_CH parallel channel registers.
- It is the receive end of the TDM multiplexer path.
- All channel outputs update atomically once a frame completes.
- Sits between the serial link and the per-channel consumers.

Parameters:
- NUM_CH, 4, number of channel slots per frame (legal range ≥2).
- DATA_W, 8, width of each slot word.
- CNT_W, $clog2(NUM_CH), width of the slot counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- din  in  DATA_W  slot word.
- din_valid  in  1  din carries a valid slot word this cycle.
- frame_start  in  1  marks the current valid beat as slot 0; ignored unless din_valid=1.
- ch_data  out  NUM_CH*DATA_W  channel registers; channel k occupies bits [k*DATA_W +: DATA_W].
- frame_done  out  1  one-cycle pulse: ch_data has just been updated with a complete frame.
- frame_err  out  1  one-cycle pulse: the in-progress frame was aborted.
- busy  out  1  high while in RECV.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-frame):
  - state=IDLE, slot counter=0, shadow buffer=0.
  - ch_data=0, frame_done=0, frame_err=0, busy=0.
- States: IDLE, RECV.
- IDLE:
  - din_valid=1 with frame_start=1: write din to shadow[0], counter←1, go to RECV.
  - din_valid=1 without frame_start: beat is dropped, no error.
- RECV:
  - Each din_valid=1 beat with frame_start=0: shadow[counter]←din, counter increments.
  - Gaps (din_valid=0) hold state with no timeout.
- Completion: at the beat accepted with counter==NUM_CH-1, on the next clock edge:
  - ch_data←all shadow slots, with that final beat placed in slot NUM_CH-1.
  - frame_done=1 for one cycle; state→IDLE; counter←0.
  - Latency: last beat at cycle t → ch_data and frame_done visible at t+1.
- Back-to-back frames: frame_start+din_valid at cycle t+1 (the frame_done cycle) is accepted as slot 0 of a new frame, with no dead cycle.
- Abort: frame_start=1 with din_valid=1 while in RECV:
  - frame_err=1 next cycle.
  - Partial frame discarded; ch_data is not modified.
  - The same beat is taken as slot 0 of a new frame: counter←1, stay in RECV.
- frame_done and frame_err are never high in the same cycle.
- ch_data holds its value between completions.
- busy = (state==RECV).
- Counter never exceeds NUM_CH-1; no wrap-around inside a frame.

Optional Feature:
- Macro: TDM_PARITY_CHECK_EN.
- Defined:
  - Adds input port din_par (1 bit), sampled with din.
  - Each accepted beat must satisfy ^{din,din_par}==0 (even parity); any mismatch sets a sticky bad-frame flag.
  - At completion with the flag set: frame_err pulses instead of frame_done, and ch_data is not updated.
  - The flag clears on reset, on completion, and on every new slot 0 (including slot 0 of an abort restart); slot 0's own parity is then checked.
- Undefined:
  - No din_par port, no parity logic.
  - frame_err arises only from abort.

Decomposition:
- Package tdm_pkg: state enum (IDLE, RECV); default NUM_CH and DATA_W localparams; slot-index function.
- Sub-module slot_decoder: combinational one-hot write-enable decoder from counter and din_valid to NUM_CH shadow-register enables.
- The parent holds the FSM, counter, shadow buffer and output register.

Test Plan (NUM_CH=4, DATA_W=8):
- Normal frame: beats 0x11(fs), 0x22, 0x33, 0x44 on consecutive cycles → one cycle after 0x44, ch_data=0x44332211, frame_done=1 for exactly 1 cycle, busy=0.
- Gapped frame: same words with din_valid=0 for 3 cycles between each → identical result; busy=1 throughout the gaps; no frame_err.
- Abort: 0xAA(fs), 0xBB, then 0x01(fs), 0x02, 0x03, 0x04 → frame_err pulse the cycle after 0x01(fs); ch_data unchanged (previous value); then ch_data=0x04030201 with frame_done.
- Stray and back-to-back: 0x55 without fs in IDLE is ignored; two full frames with the second fs on the frame_done cycle → both frame_done pulses occur and ch_data takes each frame in turn.
- Async reset mid-frame: assert rst after 2 beats, between clock edges → all outputs 0 immediately; next full frame completes normally.
- TDM_PARITY_CHECK_EN: a frame with wrong din_par on slot 2 → frame_err, ch_data unchanged; the next clean frame → frame_done.
